// File: rtl/axi_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: m0 is read-only fetch, m1 is load/store.
// One transaction outstanding; the owner is wired straight through until its response handshake.
module axi_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m0_awaddr,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,

  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,

  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    M0_RD = 2'd1,
    M1_RD = 2'd2,
    M1_WR = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // m0 has no write path, so its write-side inputs are deliberately sunk here.
  logic w_unusedM0Wr;
  assign w_unusedM0Wr = &{1'b0, m0_awaddr, m0_awvalid, m0_wdata, m0_wstrb, m0_wvalid, m0_bready};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (m1_arvalid) begin
          w_stateNext = M1_RD;
        end else if (m1_awvalid || m1_wvalid) begin
          w_stateNext = M1_WR;
        end else if (m0_arvalid) begin
          w_stateNext = M0_RD;
        end
      end
      M0_RD, M1_RD: begin
        if (s_rvalid && s_rready) begin
          w_stateNext = IDLE;
        end
      end
      M1_WR: begin
        if (s_bvalid && s_bready) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Everything not belonging to the owner's active channels is held at zero.
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = 32'h0;
    m0_rresp   = 2'b00;
    m0_rvalid  = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bresp   = 2'b00;
    m0_bvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = 32'h0;
    m1_rresp   = 2'b00;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = 2'b00;
    m1_bvalid  = 1'b0;
    s_araddr   = 32'h0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = 32'h0;
    s_awvalid  = 1'b0;
    s_wdata    = 32'h0;
    s_wstrb    = 4'h0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    case (r_state)
      M0_RD: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      M1_RD: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      M1_WR: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        m1_awready = s_awready;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        m1_wready  = s_wready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: a per-cycle read-path vector table plus
// hand-written write, priority and reset-mid-transaction sequences.
module tb_axi_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic [1:0]  m0_rresp, m0_bresp;
  logic [3:0]  m0_wstrb;
  logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [1:0]  m1_rresp, m1_bresp;
  logic [3:0]  m1_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_wstrb;

  int assertCount = 0;
  int failCount   = 0;

  axi_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected groups: expSAr = {s_arvalid, s_araddr, s_rready},
  // expM0R/expM1R = {arready, rvalid, rdata, rresp}.
  typedef struct packed {
    logic        m0Arvalid;
    logic [31:0] m0Araddr;
    logic        m0Rready;
    logic        m0Wr;
    logic        m1Arvalid;
    logic [31:0] m1Araddr;
    logic        m1Rready;
    logic        sArready;
    logic [31:0] sRdata;
    logic [1:0]  sRresp;
    logic        sRvalid;
    logic [33:0] expSAr;
    logic [35:0] expM0R;
    logic [35:0] expM1R;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearInputs();
    m0_araddr = 32'h0; m0_arvalid = 1'b0; m0_rready = 1'b0;
    m0_awaddr = 32'h0; m0_awvalid = 1'b0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m0_wvalid = 1'b0; m0_bready = 1'b0;
    m1_araddr = 32'h0; m1_arvalid = 1'b0; m1_rready = 1'b0;
    m1_awaddr = 32'h0; m1_awvalid = 1'b0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    m1_wvalid = 1'b0; m1_bready = 1'b0;
    s_arready = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
  endtask

  // m0's write channel gets busy-looking values whenever m0Wr is set; they must be ignored.
  task automatic applyStimulus(input vec_t v);
    clearInputs();
    m0_arvalid = v.m0Arvalid;
    m0_araddr  = v.m0Araddr;
    m0_rready  = v.m0Rready;
    m0_awvalid = v.m0Wr;
    m0_wvalid  = v.m0Wr;
    m0_bready  = v.m0Wr;
    m0_awaddr  = v.m0Wr ? 32'h80003000 : 32'h0;
    m0_wdata   = v.m0Wr ? 32'hCAFEF00D : 32'h0;
    m0_wstrb   = v.m0Wr ? 4'hF : 4'h0;
    m1_arvalid = v.m1Arvalid;
    m1_araddr  = v.m1Araddr;
    m1_rready  = v.m1Rready;
    s_arready  = v.sArready;
    s_rdata    = v.sRdata;
    s_rresp    = v.sRresp;
    s_rvalid   = v.sRvalid;
    s_awready  = v.m0Wr;
    s_wready   = v.m0Wr;
    s_bvalid   = v.m0Wr;
  endtask

  initial begin
    // m0 read of 0x80000000 returning 0x413, then IDLE ignores a lingering rvalid.
    vecs.push_back('{1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0,
                     34'h0, 36'h0, 36'h0});
    vecs.push_back('{1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0,
                     {1'b1, 32'h80000000, 1'b0}, {1'b1, 1'b0, 32'h0, 2'd0}, 36'h0});
    vecs.push_back('{1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00000413, 2'd0, 1'b1,
                     {1'b0, 32'h80000000, 1'b1}, {1'b0, 1'b1, 32'h00000413, 2'd0}, 36'h0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00000413, 2'd0, 1'b1,
                     34'h0, 36'h0, 36'h0});
    // Simultaneous reads: m1 wins, returns SLVERR; m0 granted after one IDLE cycle.
    vecs.push_back('{1'b1, 32'h80000010, 1'b0, 1'b0, 1'b1, 32'h80000020, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0,
                     34'h0, 36'h0, 36'h0});
    vecs.push_back('{1'b1, 32'h80000010, 1'b0, 1'b0, 1'b1, 32'h80000020, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0,
                     {1'b1, 32'h80000020, 1'b0}, 36'h0, {1'b1, 1'b0, 32'h0, 2'd0}});
    vecs.push_back('{1'b1, 32'h80000010, 1'b0, 1'b0, 1'b0, 32'h80000020, 1'b1, 1'b0, 32'h11111111, 2'd2, 1'b1,
                     {1'b0, 32'h80000020, 1'b1}, 36'h0, {1'b0, 1'b1, 32'h11111111, 2'd2}});
    vecs.push_back('{1'b1, 32'h80000010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0,
                     34'h0, 36'h0, 36'h0});
    vecs.push_back('{1'b1, 32'h80000010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0,
                     {1'b1, 32'h80000010, 1'b0}, {1'b1, 1'b0, 32'h0, 2'd0}, 36'h0});
    // rvalid without rready must not complete the transaction.
    vecs.push_back('{1'b0, 32'h80000010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h22222222, 2'd0, 1'b1,
                     {1'b0, 32'h80000010, 1'b0}, {1'b0, 1'b1, 32'h22222222, 2'd0}, 36'h0});
    vecs.push_back('{1'b0, 32'h80000010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h22222222, 2'd0, 1'b1,
                     {1'b0, 32'h80000010, 1'b1}, {1'b0, 1'b1, 32'h22222222, 2'd0}, 36'h0});
    // m0 write attempts never get a grant.
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0,
                     34'h0, 36'h0, 36'h0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0,
                     34'h0, 36'h0, 36'h0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0,
                     34'h0, 36'h0, 36'h0});

    // Reset with busy-looking inputs: every output must be zero.
    clearInputs();
    rst = 1'b1;
    m1_arvalid = 1'b1; m0_arvalid = 1'b1; s_rvalid = 1'b1; s_arready = 1'b1;
    s_bvalid = 1'b1; s_rdata = 32'h12345678;
    #1;
    checkOutput("rstSlave", {s_arvalid, s_araddr, s_rready, s_awvalid, s_wvalid, s_bready}, 128'h0);
    checkOutput("rstMasters", {m0_arready, m0_rvalid, m0_rdata, m1_arready, m1_rvalid, m1_rdata, m1_bvalid}, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearInputs();

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_sAr", i), {s_arvalid, s_araddr, s_rready}, vecs[i].expSAr);
      checkOutput($sformatf("v%0d_m0R", i), {m0_arready, m0_rvalid, m0_rdata, m0_rresp}, vecs[i].expM0R);
      checkOutput($sformatf("v%0d_m1R", i), {m1_arready, m1_rvalid, m1_rdata, m1_rresp}, vecs[i].expM1R);
      checkOutput($sformatf("v%0d_m0Wr", i), {m0_awready, m0_wready, m0_bvalid, m0_bresp}, 128'h0);
      checkOutput($sformatf("v%0d_wrIdle", i),
                  {s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready, m1_awready, m1_wready, m1_bvalid}, 128'h0);
    end

    // m1 write, W before AW, while m0 holds arvalid; DECERR forwarded on B.
    @(negedge clk);
    clearInputs();
    m0_arvalid = 1'b1; m0_araddr = 32'h80000030;
    m1_wvalid = 1'b1; m1_wdata = 32'hDEADBEEF; m1_wstrb = 4'hF; m1_awaddr = 32'h80001000;
    #1;
    checkOutput("wIdle0", {m0_arready, s_arvalid, s_wvalid, m1_wready}, 128'h0);
    @(negedge clk);
    s_wready = 1'b1;
    #1;
    checkOutput("wData", {s_wvalid, s_wdata, s_wstrb, m1_wready, s_awvalid}, {1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0});
    checkOutput("wHoldM0", {m0_arready, s_arvalid}, 128'h0);
    @(negedge clk);
    m1_wvalid = 1'b0; s_wready = 1'b0; m1_awvalid = 1'b1; s_awready = 1'b1;
    #1;
    checkOutput("wAddr", {s_awvalid, s_awaddr, m1_awready, s_wvalid}, {1'b1, 32'h80001000, 1'b1, 1'b0});
    @(negedge clk);
    m1_awvalid = 1'b0; s_awready = 1'b0; m1_bready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b11;
    #1;
    checkOutput("wResp", {m1_bvalid, m1_bresp, s_bready, m0_arready}, {1'b1, 2'b11, 1'b1, 1'b0});
    @(negedge clk);
    m1_bready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
    #1;
    checkOutput("wIdle1", {m1_bvalid, m0_arready, s_arvalid, s_bready}, 128'h0);
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    checkOutput("wM0Grant", {s_arvalid, s_araddr, m0_arready}, {1'b1, 32'h80000030, 1'b1});
    @(negedge clk);
    m0_arvalid = 1'b0; s_arready = 1'b0; m0_rready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h00000033;
    #1;
    checkOutput("wM0Data", {m0_rvalid, m0_rdata, s_rready}, {1'b1, 32'h00000033, 1'b1});

    // m1 read beats m1 write; reset lands while rvalid is pending.
    @(negedge clk);
    clearInputs();
    m1_arvalid = 1'b1; m1_araddr = 32'h80000040; m1_awvalid = 1'b1; m1_awaddr = 32'h80002000;
    #1;
    checkOutput("xIdle", {s_arvalid, s_awvalid}, 128'h0);
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    checkOutput("xRdPri", {s_arvalid, s_araddr, s_awvalid, m1_awready}, {1'b1, 32'h80000040, 1'b0, 1'b0});
    @(negedge clk);
    s_arready = 1'b0; m1_rready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h00000044;
    #1;
    checkOutput("xPend", {s_arvalid, s_rready, m1_rvalid}, 3'b111);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("xRst", {s_arvalid, s_rready, m1_rvalid, m1_rdata, m1_arready}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    #1;
    checkOutput("xAfter", {s_arvalid, s_rready, s_awvalid, m1_rvalid, m1_awready}, 128'h0);
    @(negedge clk);
    m0_arvalid = 1'b1; m0_araddr = 32'h80000050;
    @(negedge clk);
    #1;
    checkOutput("xRegrant", {s_arvalid, s_araddr, m1_rvalid}, {1'b1, 32'h80000050, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
